rggen_apb_request_master: RTL and testbench

//  Converts a valid/ready register-request stream (from a CPU-side bridge or test sequencer) into APB4

---
 rtl/rggen_apb_if.sv | 29 ++
 rtl/rggen_apb_request_master.sv | 124 ++++++++++++
 tb/tb_rggen_apb_request_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rggen_apb_if.sv
// APB4 bus bundle shared by the request master and a register-block slave.
//   master modport: drives psel/penable/paddr/pprot/pwrite/pstrb/pwdata,
//                   samples pready/prdata/pslverr.
//   slave modport : the reverse direction of every signal.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_request_master.sv
// Turns a valid/ready register-request stream into single APB4 transfers and
// returns one response (read data + status) per request.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_req_*/o_req_ready     : request channel (write flag, byte address, data, strobe)
//   o_rsp_*/i_rsp_ready     : response channel (read data, status 00 OK / 10 SLVERR / 11 TIMEOUT)
//   apb_if                  : APB4 master port
// One transfer is outstanding at a time. A watchdog aborts an ACCESS phase
// that lasts TIMEOUT_CYCLES cycles without pready (0 disables it).
module rggen_apb_request_master #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [BUS_WIDTH-1:0]     i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  rggen_apb_if.master              apb_if
);
  localparam int SW = BUS_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_e;

  state_e                   state_q, state_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]            strobe_q, strobe_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]               status_q, status_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     expired;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      rdata_q  <= '0;
      status_q <= 2'b00;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      count_q  <= count_d;
    end
  end

  // count_q holds the number of pready-less ACCESS cycles already spent, so
  // the current cycle is the last permitted one when it equals TIMEOUT-1.
  assign expired = (TIMEOUT_CYCLES != 0) && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          write_d  = i_req_write;
          addr_d   = i_req_address;
          wdata_d  = i_req_write_data;
          strobe_d = i_req_strobe;
          count_d  = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready on the expiry cycle still completes normally
        if (apb_if.pready) begin
          rdata_d  = write_q ? '0 : apb_if.prdata;
          status_d = apb_if.pslverr ? 2'b10 : 2'b00;
          state_d  = RESPONSE;
        end else if (expired) begin
          rdata_d  = '0;
          status_d = 2'b11;
          state_d  = RESPONSE;
        end else begin
          count_d  = count_q + CW'(1);
        end
      end
      RESPONSE: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready       = (state_q == IDLE);
    o_rsp_valid       = (state_q == RESPONSE);
    o_rsp_read_data   = rdata_q;
    o_rsp_status      = status_q;
    apb_if.psel       = (state_q == SETUP) || (state_q == ACCESS);
    apb_if.penable    = (state_q == ACCESS);
    apb_if.paddr      = addr_q;
    apb_if.pprot      = 3'b000;
    apb_if.pwrite     = write_q;
    apb_if.pwdata     = wdata_q;
    apb_if.pstrb      = write_q ? strobe_q : '0;
  end
endmodule

// File: tb/tb_rggen_apb_request_master.sv
module tb_rggen_apb_request_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  int n_cmp = 0;
  int n_err = 0;

  rggen_apb_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) apb ();

  rggen_apb_request_master #(
    .ADDRESS_WIDTH(16), .BUS_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_address(req_addr),
    .i_req_write_data(req_wdata), .i_req_strobe(req_strb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_read_data(rsp_rdata), .o_rsp_status(rsp_status),
    .apb_if(apb)
  );

  always #5 clk = ~clk;

  // APB slave: 16 words at 0x0000-0x003F, pready after cur_wait stalled cycles.
  logic [31:0] mem [16];
  logic [7:0]  wcnt;
  int          cur_wait = 0;
  logic        err_en = 1'b0;
  logic        mapped_bus;

  assign mapped_bus  = (apb.paddr < 16'h0040);
  assign apb.pready  = apb.psel && apb.penable && (int'(wcnt) == cur_wait);
  assign apb.prdata  = (apb.psel && apb.penable && mapped_bus) ? mem[apb.paddr[5:2]] : '0;
  assign apb.pslverr = apb.pready && !mapped_bus && err_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (apb.psel && apb.penable && !apb.pready) wcnt <= wcnt + 8'd1;
      else wcnt <= '0;
      if (apb.psel && apb.penable && apb.pready && apb.pwrite && mapped_bus)
        for (int b = 0; b < 4; b++)
          if (apb.pstrb[b]) mem[apb.paddr[5:2]][8*b +: 8] <= apb.pwdata[8*b +: 8];
    end
  end

  // Reference model: expected register contents seen through the bus.
  logic [31:0] ref_mem [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one request; w = stalled ACCESS cycles before pready, hold = extra
  // response cycles with rsp_ready low, keep = keep req_valid high throughout.
  task automatic txn(input logic wr, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int w, input int hold, input logic keep);
    logic        mapped, timeout;
    int          acc;
    logic [1:0]  exp_st;
    logic [31:0] exp_rd, pw;
    logic [3:0]  ps;
    mapped  = (a < 16'h0040);
    timeout = (w >= TO);
    acc     = timeout ? TO : w + 1;
    exp_st  = timeout ? 2'b11 : (!mapped && err_en) ? 2'b10 : 2'b00;
    exp_rd  = (timeout || wr || !mapped) ? 32'h0 : ref_mem[a[5:2]];
    ps      = wr ? s : 4'h0;
    pw      = d;
    if (!timeout && wr && mapped)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];

    cur_wait  = w;
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
    check("idle_req_ready", req_ready, 1);
    @(posedge clk); @(negedge clk);
    if (!keep) req_valid = 1'b0;
    check("setup_psel", apb.psel, 1);
    check("setup_penable", apb.penable, 0);
    check("setup_req_ready", req_ready, 0);
    check("setup_paddr", apb.paddr, a);
    check("setup_pwrite", apb.pwrite, wr);
    check("setup_pstrb", apb.pstrb, ps);
    check("setup_pprot", apb.pprot, 0);
    for (int k = 0; k < acc; k++) begin
      @(negedge clk);
      check("acc_psel_penable", {apb.psel, apb.penable}, 2'b11);
      check("acc_paddr", apb.paddr, a);
      check("acc_pwdata", apb.pwdata, pw);
      check("acc_pstrb", apb.pstrb, ps);
      check("acc_req_ready", req_ready, 0);
    end
    @(negedge clk);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_psel_penable", {apb.psel, apb.penable}, 2'b00);
    check("rsp_data", rsp_rdata, exp_rd);
    check("rsp_status", rsp_status, exp_st);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_rdata, exp_rd);
      check("hold_rsp_status", rsp_status, exp_st);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_psel", apb.psel, 0);
    check("rst_penable", apb.penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_data", rsp_rdata, 0);
    check("rst_paddr", apb.paddr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    // directed cases
    txn(1'b1, 16'h0000, 32'h0000_00A5, 4'hF, 0, 0, 1'b0);
    txn(1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 1'b0);
    txn(1'b1, 16'h0008, 32'hDEAD_BEEF, 4'h5, 3, 0, 1'b0);
    txn(1'b0, 16'h0008, 32'h0, 4'hF, 3, 0, 1'b0);
    err_en = 1'b1;
    txn(1'b0, 16'h007C, 32'h0, 4'hF, 0, 0, 1'b0);
    err_en = 1'b0;
    txn(1'b0, 16'h0000, 32'h0, 4'h0, 6, 0, 1'b0);
    txn(1'b1, 16'h0004, 32'h1234_5678, 4'hF, 9, 0, 1'b0);
    txn(1'b0, 16'h0004, 32'h0, 4'h0, 0, 0, 1'b0);
    txn(1'b0, 16'h0000, 32'h0, 4'h0, TO - 1, 0, 1'b0);
    txn(1'b0, 16'h0008, 32'h0, 4'h0, 1, 5, 1'b1);

    // reset in the middle of an ACCESS phase
    cur_wait = 10;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0004;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_penable", apb.penable, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_psel", apb.psel, 0);
    check("mid_rst_penable", apb.penable, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after_rst_rsp_valid", rsp_valid, 0);
      check("after_rst_req_ready", req_ready, 1);
      check("after_rst_psel", apb.psel, 0);
    end

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic        wr;
      logic [15:0] a;
      int          w;
      int          sel;
      wr     = 1'($urandom_range(0, 1));
      a      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(64, 255))
                                           : 16'($urandom_range(0, 63));
      sel    = $urandom_range(0, 7);
      w      = (sel < 2) ? 0 : (sel < 6) ? sel - 2 : sel - 1;
      err_en = 1'($urandom_range(0, 1));
      txn(wr, a, $urandom, 4'($urandom_range(0, 15)), w,
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
